// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Iterative double-dabble binary-to-BCD converter, one bit per
//            clock. Optional two's complement input when BCD_SIGNED_INPUT_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq #(
    parameter int W = 10
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [15:0]  bcd,
    output logic         sign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_INIT = 4'(W);

    state_t         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [15:0]    scratch_q, scratch_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    bcd_q, bcd_d;
    logic           sign_q, sign_d;
    logic           sign_cap_q, sign_cap_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic [W-1:0]   w_mag;
    logic           w_sign;
    logic [15:0]    w_adj;
    logic [15+W:0]  w_shifted;

`ifdef BCD_SIGNED_INPUT_EN
    // Most negative input wraps to 2^(W-1), which is exactly the magnitude wanted.
    assign w_sign = bin[W-1];
    assign w_mag  = bin[W-1] ? ((~bin) + W'(1)) : bin;
`else
    assign w_sign = 1'b0;
    assign w_mag  = bin;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_digit_adj
        assign w_adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ?
                                 (scratch_q[4*i +: 4] + 4'd3) :
                                 scratch_q[4*i +: 4];
    end

    assign w_shifted = {w_adj, shift_q} << 1;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        sign_cap_d = sign_cap_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d    = w_mag;
                    sign_cap_d = w_sign;
                    scratch_d  = 16'h0000;
                    cnt_d      = C_CNT_INIT;
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                scratch_d = w_shifted[15+W:W];
                shift_d   = w_shifted[W-1:0];
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    bcd_d   = w_shifted[15+W:W];
                    sign_d  = sign_cap_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            scratch_q  <= 16'h0000;
            cnt_q      <= 4'd0;
            bcd_q      <= 16'h0000;
            sign_q     <= 1'b0;
            sign_cap_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            sign_cap_q <= sign_cap_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign sign = sign_q;

endmodule

`default_nettype wire
